// File: rtl/metadata_builder_pkg.sv
// -----------------------------------------------------------------------------
// metadata_builder_pkg
// Shared definitions for the metadata builder:
//   - FAST packet beat geometry and beat-type encodings
//   - Ethernet beat indices that carry the IPv4/TCP header fields
//   - metadata word field offsets and the function that packs a word
//   - protocol constants used to qualify a packet as well-formed TCP
// No ports (package).
// -----------------------------------------------------------------------------
package metadata_builder_pkg;

    localparam int W_PKT       = 134;
    localparam int W_META      = 209;
    localparam int W_CNT       = 32;
    localparam int W_DATA      = 128;
    localparam int N_LANES     = 16;
    localparam int N_FAST_META = 2;

    // Beat index counter saturates here; packets may be longer.
    localparam logic [3:0] K_MAX = 4'd15;

    // Beat indices holding Ethernet bytes 0-15, 16-31, 32-47, 48-63.
    localparam logic [3:0] K_ETH0 = 4'(N_FAST_META);
    localparam logic [3:0] K_ETH1 = 4'(N_FAST_META + 1);
    localparam logic [3:0] K_ETH2 = 4'(N_FAST_META + 2);
    localparam logic [3:0] K_ETH3 = 4'(N_FAST_META + 3);

    typedef enum logic [1:0] {
        BEAT_NONE = 2'b00,
        BEAT_HEAD = 2'b01,
        BEAT_TAIL = 2'b10,
        BEAT_MID  = 2'b11
    } beat_type_t;

    typedef enum logic {
        ST_IDLE,
        ST_PARSE
    } parse_state_t;

    // Metadata word layout (LSB positions).
    localparam int META_HIT       = 208;
    localparam int META_TUPLE_LSB = 104;   // {srcIP, dstIP, sport, dport, proto}
    localparam int META_LEN_LSB   = 88;
    localparam int META_FLAGS_LSB = 80;
    localparam int META_SEQ_LSB   = 48;
    localparam int META_ACK_LSB   = 16;
    localparam int META_WIN_LSB   = 0;

    localparam logic [15:0] ETH_IPV4        = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL5   = 8'h45;
    localparam logic [7:0]  PROTO_TCP       = 8'h06;
    localparam logic [3:0]  TCP_MIN_DATAOFF = 4'd5;

    typedef struct packed {
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [15:0] totlen;
        logic [7:0]  proto;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [3:0]  dataoff;
        logic [7:0]  flags;
        logic [15:0] window;
    } hdr_t;

    // TCP payload length; a total length shorter than the headers yields 0.
    function automatic logic [15:0] content_len(input logic [15:0] totlen,
                                                input logic [3:0]  dataoff);
        logic [15:0] hdr_len;
        hdr_len = 16'd20 + {10'd0, dataoff, 2'b00};
        return (totlen > hdr_len) ? (totlen - hdr_len) : 16'd0;
    endfunction

    function automatic logic [W_META-1:0] pack_meta(input hdr_t h);
        logic [W_META-1:0] m;
        m = '0;
        m[META_HIT]                = 1'b0;
        m[META_TUPLE_LSB +: 104]   = {h.src_ip, h.dst_ip, h.sport, h.dport, h.proto};
        m[META_LEN_LSB   +: 16]    = content_len(h.totlen, h.dataoff);
        m[META_FLAGS_LSB +: 8]     = h.flags;
        m[META_SEQ_LSB   +: 32]    = h.seq;
        m[META_ACK_LSB   +: 32]    = h.ack;
        m[META_WIN_LSB   +: 16]    = h.window;
        return m;
    endfunction

endpackage

// File: rtl/metadata_builder_if.sv
// -----------------------------------------------------------------------------
// metadata_builder_if
// Bundles the packet-input stream and the metadata output handshake.
//   pkt_in_valid / pkt_in / pkt_in_ready         : FAST beat stream into the builder
//   metadata_out_valid / metadata_out / ready    : metadata word towards the consumer
// Modports:
//   slave  : the metadata builder (consumes beats, produces metadata)
//   master : the environment (produces beats, consumes metadata)
// -----------------------------------------------------------------------------
interface metadata_builder_if;
    import metadata_builder_pkg::*;

    logic              pkt_in_valid;
    logic [W_PKT-1:0]  pkt_in;
    logic              pkt_in_ready;
    logic              metadata_out_valid;
    logic [W_META-1:0] metadata_out;
    logic              ready;

    modport slave (
        input  pkt_in_valid, pkt_in, ready,
        output pkt_in_ready, metadata_out_valid, metadata_out
    );

    modport master (
        output pkt_in_valid, pkt_in, ready,
        input  pkt_in_ready, metadata_out_valid, metadata_out
    );

endinterface

// File: rtl/metadata_builder_meta_out_reg.sv
// -----------------------------------------------------------------------------
// meta_out_reg
// One-entry valid/ready holding register for metadata words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data this cycle (only asserted while accept=1)
//   load_data   : metadata word to capture
//   ready       : consumer ready; transfer on valid & ready
//   valid, data : held metadata word
//   accept      : upstream may advance (slot empty or draining this cycle)
// -----------------------------------------------------------------------------
module meta_out_reg
    import metadata_builder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [W_META-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [W_META-1:0] data,
    output logic              accept
);

    logic              valid_reg;
    logic [W_META-1:0] data_reg;

    // A load in the same cycle as a transfer replaces the word with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid  = valid_reg;
    assign data   = data_reg;
    assign accept = !(valid_reg && !ready);

endmodule

// File: rtl/metadata_builder.sv
// -----------------------------------------------------------------------------
// metadata_builder
// Snoops the FAST packet stream, parses the IPv4/TCP header and emits one
// metadata word per well-formed TCP packet, held until the consumer is ready.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : packet input stream + metadata output handshake (slave side)
//   meta_cnt   : metadata words transferred (wraps)
//   drop_cnt   : packets not emitted: non-TCP, malformed, truncated or
//                interrupted by a new head (wraps)
// -----------------------------------------------------------------------------
module metadata_builder
    import metadata_builder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    metadata_builder_if.slave bus,
    output logic [W_CNT-1:0]  meta_cnt,
    output logic [W_CNT-1:0]  drop_cnt
);

    parse_state_t      state_reg;
    logic [3:0]        k_reg;
    hdr_t              hdr_reg;
    hdr_t              hdr_next;
    logic [W_CNT-1:0]  meta_cnt_reg;
    logic [W_CNT-1:0]  drop_cnt_reg;

    logic              in_ready;
    logic              out_valid;
    logic [W_META-1:0] out_data;
    logic              beat_fire;
    beat_type_t        beat_type;
    logic              hdr_ok;
    logic              tail_done;
    logic              emit;
    logic [3:0]        unused_invalid;
    logic [7:0]        lane [N_LANES];

    assign beat_fire      = bus.pkt_in_valid && in_ready;
    assign beat_type      = beat_type_t'(bus.pkt_in[W_PKT-1 -: 2]);
    assign unused_invalid = bus.pkt_in[W_PKT-3 -: 4];

    // Byte lane 0 sits in the most significant byte of the data field.
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign lane[gi] = bus.pkt_in[W_DATA-1-8*gi -: 8];
        end
    endgenerate

    // Header fields as they will look after the current beat is captured.
    // The tail beat itself may carry fields, so emit decisions use this view.
    always_comb begin
        hdr_next = hdr_reg;
        if (state_reg == ST_PARSE) begin
            case (k_reg)
                K_ETH0: begin
                    hdr_next.ethertype = {lane[12], lane[13]};
                    hdr_next.ver_ihl   = lane[14];
                end
                K_ETH1: begin
                    hdr_next.totlen        = {lane[0], lane[1]};
                    hdr_next.proto         = lane[7];
                    hdr_next.src_ip        = {lane[10], lane[11], lane[12], lane[13]};
                    hdr_next.dst_ip[31:16] = {lane[14], lane[15]};
                end
                K_ETH2: begin
                    hdr_next.dst_ip[15:0] = {lane[0], lane[1]};
                    hdr_next.sport        = {lane[2], lane[3]};
                    hdr_next.dport        = {lane[4], lane[5]};
                    hdr_next.seq          = {lane[6], lane[7], lane[8], lane[9]};
                    hdr_next.ack          = {lane[10], lane[11], lane[12], lane[13]};
                    hdr_next.dataoff      = lane[14][7:4];
                    hdr_next.flags        = lane[15];
                end
                K_ETH3: begin
                    hdr_next.window = {lane[0], lane[1]};
                end
                default: ;
            endcase
        end
    end

    assign hdr_ok = (hdr_next.ethertype == ETH_IPV4)
                 && (hdr_next.ver_ihl   == IPV4_VER_IHL5)
                 && (hdr_next.proto     == PROTO_TCP)
                 && (hdr_next.dataoff   >= TCP_MIN_DATAOFF);

    assign tail_done = beat_fire && (state_reg == ST_PARSE) && (beat_type == BEAT_TAIL);
    assign emit      = tail_done && (k_reg >= K_ETH3) && hdr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            k_reg        <= 4'd0;
            hdr_reg      <= '0;
            meta_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (out_valid && bus.ready) begin
                meta_cnt_reg <= meta_cnt_reg + W_CNT'(1);
            end
            if (beat_fire) begin
                case (state_reg)
                    ST_IDLE: begin
                        // Orphan middle/tail beats are silently discarded.
                        if (beat_type == BEAT_HEAD) begin
                            state_reg <= ST_PARSE;
                            k_reg     <= 4'd1;
                        end
                    end
                    ST_PARSE: begin
                        hdr_reg <= hdr_next;
                        if (beat_type == BEAT_HEAD) begin
                            // Previous packet lost its tail: count it, restart.
                            k_reg        <= 4'd1;
                            drop_cnt_reg <= drop_cnt_reg + W_CNT'(1);
                        end else if (beat_type == BEAT_TAIL) begin
                            state_reg <= ST_IDLE;
                            k_reg     <= 4'd0;
                            if (!emit) begin
                                drop_cnt_reg <= drop_cnt_reg + W_CNT'(1);
                            end
                        end else if (k_reg != K_MAX) begin
                            k_reg <= k_reg + 4'd1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        k_reg     <= 4'd0;
                    end
                endcase
            end
        end
    end

    meta_out_reg u_meta_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit),
        .load_data (pack_meta(hdr_next)),
        .ready     (bus.ready),
        .valid     (out_valid),
        .data      (out_data),
        .accept    (in_ready)
    );

    assign bus.pkt_in_ready       = in_ready;
    assign bus.metadata_out_valid = out_valid;
    assign bus.metadata_out       = out_data;
    assign meta_cnt               = meta_cnt_reg;
    assign drop_cnt               = drop_cnt_reg;

endmodule

// File: tb/tb_metadata_builder.sv
// -----------------------------------------------------------------------------
// tb_metadata_builder
// Directed self-checking bench for metadata_builder. Packets are assembled
// from a byte image of the Ethernet/IPv4/TCP header and driven beat by beat;
// expected metadata words are hand-written constants.
// -----------------------------------------------------------------------------
module tb_metadata_builder;
    import metadata_builder_pkg::*;

    localparam int BEAT_TIMEOUT = 100;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_MID  = 2'b11;
    localparam logic [1:0] T_TAIL = 2'b10;

    // {hit, srcIP, dstIP, sport, dport, proto, len, flags, seq, ack, window}
    localparam logic [W_META-1:0] EXP_SYN = {1'b0, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 8'h06,
                                             16'h0000, 8'h02, 32'h11223344, 32'h00000000, 16'hFFFF};
    // totlen 140, dataoff 8: 140 - 20 - 32 = 88
    localparam logic [W_META-1:0] EXP_L88 = {1'b0, 32'h0A000001, 32'h0A000002, 16'h04D3, 16'h0050, 8'h06,
                                             16'h0058, 8'h18, 32'h00000100, 32'h00000200, 16'h1234};
    // totlen 140, dataoff 13: 140 - 20 - 52 = 68
    localparam logic [W_META-1:0] EXP_L68 = {1'b0, 32'h0A000001, 32'h0A000002, 16'h04D4, 16'h0050, 8'h06,
                                             16'h0044, 8'h10, 32'h00000055, 32'h00000066, 16'h2000};
    // totlen 30, dataoff 5: underflow saturates to 0
    localparam logic [W_META-1:0] EXP_L0  = {1'b0, 32'h0A000001, 32'h0A000002, 16'h04D5, 16'h0050, 8'h06,
                                             16'h0000, 8'h11, 32'h00000077, 32'h00000088, 16'h0001};
    localparam logic [W_META-1:0] EXP_A   = {1'b0, 32'h0A000001, 32'h0A000002, 16'h1000, 16'h0050, 8'h06,
                                             16'h0000, 8'h02, 32'hA0A0A0A0, 32'h00000000, 16'h4000};
    // totlen 60, dataoff 5: 20
    localparam logic [W_META-1:0] EXP_B   = {1'b0, 32'h0A000001, 32'h0A000002, 16'h2000, 16'h0050, 8'h06,
                                             16'h0014, 8'h10, 32'hB0B0B0B0, 32'h00000001, 16'h5000};
    // totlen 100, dataoff 5: 60
    localparam logic [W_META-1:0] EXP_C   = {1'b0, 32'h0A000001, 32'h0A000002, 16'h3000, 16'h0050, 8'h06,
                                             16'h003C, 8'h18, 32'hC0C0C0C0, 32'hC1C1C1C1, 16'h6000};
    // totlen 52, dataoff 8: exactly header length -> 0
    localparam logic [W_META-1:0] EXP_D   = {1'b0, 32'h0A000001, 32'h0A000002, 16'h4000, 16'h0050, 8'h06,
                                             16'h0000, 8'h10, 32'hD0D0D0D0, 32'hD1D1D1D1, 16'h7000};

    logic             clk;
    logic             reset;
    logic [W_CNT-1:0] meta_cnt;
    logic [W_CNT-1:0] drop_cnt;

    int checks     = 0;
    int errors     = 0;
    int acc_count  = 0;

    logic [7:0]        eth [0:95];
    logic [W_META-1:0] words [$];

    metadata_builder_if bus ();

    metadata_builder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .meta_cnt (meta_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every word that transfers at the following rising edge.
    always @(negedge clk) begin
        #2;
        if (bus.metadata_out_valid && bus.ready && !reset) begin
            words.push_back(bus.metadata_out);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W_META-1:0] obs, input logic [W_META-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_eth(input logic [15:0] etype, input logic [7:0] vihl, input logic [7:0] proto,
                             input logic [15:0] totlen, input logic [3:0] doff, input logic [7:0] flags,
                             input logic [15:0] sport, input logic [31:0] seq, input logic [31:0] ack,
                             input logic [15:0] win);
        for (int i = 0; i < 96; i++) eth[i] = 8'(i * 3 + 1);
        {eth[12], eth[13]} = etype;
        eth[14] = vihl;
        {eth[16], eth[17]} = totlen;
        eth[23] = proto;
        {eth[26], eth[27], eth[28], eth[29]} = 32'h0A000001;
        {eth[30], eth[31], eth[32], eth[33]} = 32'h0A000002;
        {eth[34], eth[35]} = sport;
        {eth[36], eth[37]} = 16'h0050;
        {eth[38], eth[39], eth[40], eth[41]} = seq;
        {eth[42], eth[43], eth[44], eth[45]} = ack;
        eth[46] = {doff, 4'h0};
        eth[47] = flags;
        {eth[48], eth[49]} = win;
    endtask

    function automatic logic [127:0] beat_data(input int k);
        logic [127:0] d;
        d = '0;
        if (k < 2) begin
            d = {112'h0, 8'hFA, 8'(k)};
        end else begin
            for (int l = 0; l < 16; l++) d[127-8*l -: 8] = eth[(k-2)*16 + l];
        end
        return d;
    endfunction

    task automatic send_beat(input logic [1:0] bt, input logic [127:0] data);
        int   waited;
        logic acc;
        waited = 0;
        @(negedge clk);
        bus.pkt_in_valid = 1'b1;
        bus.pkt_in       = {bt, 4'd0, data};
        forever begin
            #1 acc = bus.pkt_in_ready;
            @(posedge clk);
            if (acc) begin
                acc_count++;
                break;
            end
            waited++;
            if (waited > BEAT_TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout waited=%0d limit=%0d", waited, BEAT_TIMEOUT);
                break;
            end
            @(negedge clk);
        end
        #1 bus.pkt_in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] etype, input logic [7:0] vihl, input logic [7:0] proto,
                            input logic [15:0] totlen, input logic [3:0] doff, input logic [7:0] flags,
                            input logic [15:0] sport, input logic [31:0] seq, input logic [31:0] ack,
                            input logic [15:0] win, input int nbeats);
        build_eth(etype, vihl, proto, totlen, doff, flags, sport, seq, ack, win);
        for (int k = 0; k < nbeats; k++) begin
            send_beat((k == 0) ? T_HEAD : ((k == nbeats - 1) ? T_TAIL : T_MID), beat_data(k));
        end
    endtask

    logic stable;
    int   acc_before;

    initial begin
        reset            = 1'b1;
        bus.pkt_in_valid = 1'b0;
        bus.pkt_in       = '0;
        bus.ready        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  bus.pkt_in_ready, 1);
        check("rst_out_valid", bus.metadata_out_valid, 0);
        check("rst_out_data",  bus.metadata_out, 0);
        check("rst_meta_cnt",  meta_cnt, 0);
        check("rst_drop_cnt",  drop_cnt, 0);
        reset = 1'b0;

        // TCP SYN, tail at beat 5, consumer ready
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h04D2, 32'h11223344, 32'h0, 16'hFFFF, 6);
        @(negedge clk);
        check("syn_valid", bus.metadata_out_valid, 1);
        check("syn_word",  bus.metadata_out, EXP_SYN);
        @(negedge clk);
        check("syn_valid_clear", bus.metadata_out_valid, 0);
        check("syn_meta_cnt",    meta_cnt, 1);
        check("syn_drop_cnt",    drop_cnt, 0);

        // Content-length cases (first one is a 7-beat packet)
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd140, 4'd8, 8'h18, 16'h04D3, 32'h100, 32'h200, 16'h1234, 7);
        @(negedge clk);
        check("len88_word", bus.metadata_out, EXP_L88);
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd140, 4'd13, 8'h10, 16'h04D4, 32'h55, 32'h66, 16'h2000, 6);
        @(negedge clk);
        check("len68_word", bus.metadata_out, EXP_L68);
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd30, 4'd5, 8'h11, 16'h04D5, 32'h77, 32'h88, 16'h0001, 6);
        @(negedge clk);
        check("len0_word", bus.metadata_out, EXP_L0);
        @(negedge clk);
        check("len_meta_cnt", meta_cnt, 4);

        // Non-TCP / malformed packets: UDP, ARP, IHL != 5, dataoff 4
        send_pkt(16'h0800, 8'h45, 8'h11, 16'd40, 4'd5, 8'h02, 16'h0001, 32'h1, 32'h0, 16'h0001, 6);
        @(negedge clk);
        check("udp_no_valid", bus.metadata_out_valid, 0);
        send_pkt(16'h0806, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h0001, 32'h1, 32'h0, 16'h0001, 6);
        @(negedge clk);
        check("arp_no_valid", bus.metadata_out_valid, 0);
        check("arp_drop_cnt", drop_cnt, 2);
        send_pkt(16'h0800, 8'h46, 8'h06, 16'd40, 4'd5, 8'h02, 16'h0001, 32'h1, 32'h0, 16'h0001, 6);
        @(negedge clk);
        check("ihl_no_valid", bus.metadata_out_valid, 0);
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd40, 4'd4, 8'h02, 16'h0001, 32'h1, 32'h0, 16'h0001, 6);
        @(negedge clk);
        check("doff4_no_valid", bus.metadata_out_valid, 0);
        check("bad_drop_cnt",   drop_cnt, 4);
        check("bad_meta_cnt",   meta_cnt, 4);

        // Backpressure: word A held while packet B stalls
        words.delete();
        bus.ready = 1'b0;
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h1000, 32'hA0A0A0A0, 32'h0, 16'h4000, 6);
        @(negedge clk);
        check("bp_a_valid",    bus.metadata_out_valid, 1);
        check("bp_a_word",     bus.metadata_out, EXP_A);
        check("bp_in_ready_0", bus.pkt_in_ready, 0);
        fork
            send_pkt(16'h0800, 8'h45, 8'h06, 16'd60, 4'd5, 8'h10, 16'h2000, 32'hB0B0B0B0, 32'h1, 16'h5000, 6);
            begin
                stable     = 1'b1;
                acc_before = acc_count;
                repeat (20) begin
                    @(negedge clk);
                    #3;
                    if (bus.metadata_out !== EXP_A || bus.pkt_in_ready !== 1'b0 ||
                        bus.metadata_out_valid !== 1'b1) stable = 1'b0;
                end
                check("bp_hold_stable", stable, 1);
                check("bp_no_beats_taken", W_META'(acc_count - acc_before), 0);
                @(negedge clk);
                bus.ready = 1'b1;
            end
        join
        @(negedge clk);
        check("bp_b_word", bus.metadata_out, EXP_B);
        @(negedge clk);
        check("bp_word_count", W_META'(words.size()), 2);
        if (words.size() == 2) begin
            check("bp_first_a",  words[0], EXP_A);
            check("bp_second_b", words[1], EXP_B);
        end
        check("bp_meta_cnt", meta_cnt, 6);

        // Head arriving mid-packet restarts the parse and counts one drop
        build_eth(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h9999, 32'h9, 32'h9, 16'h9999);
        send_beat(T_HEAD, beat_data(0));
        send_beat(T_MID,  beat_data(1));
        send_beat(T_MID,  beat_data(2));
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd100, 4'd5, 8'h18, 16'h3000, 32'hC0C0C0C0, 32'hC1C1C1C1, 16'h6000, 6);
        @(negedge clk);
        check("rehead_word",     bus.metadata_out, EXP_C);
        check("rehead_drop_cnt", drop_cnt, 5);
        @(negedge clk);
        check("rehead_meta_cnt", meta_cnt, 7);

        // Truncated packets: 3 beats, then tail one beat short of the header
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h0002, 32'h2, 32'h0, 16'h0002, 3);
        @(negedge clk);
        check("short3_no_valid", bus.metadata_out_valid, 0);
        check("short3_drop_cnt", drop_cnt, 6);
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h0003, 32'h3, 32'h0, 16'h0003, 5);
        @(negedge clk);
        check("short5_no_valid", bus.metadata_out_valid, 0);
        check("short5_drop_cnt", drop_cnt, 7);

        // Orphan tail while idle is discarded without counting
        send_beat(T_TAIL, beat_data(5));
        @(negedge clk);
        check("orphan_no_valid", bus.metadata_out_valid, 0);
        check("orphan_drop_cnt", drop_cnt, 7);

        // Reset during beat 3, then the rest of that packet, then a clean packet
        build_eth(16'h0800, 8'h45, 8'h06, 16'd40, 4'd5, 8'h02, 16'h0004, 32'h4, 32'h0, 16'h0004);
        send_beat(T_HEAD, beat_data(0));
        send_beat(T_MID,  beat_data(1));
        send_beat(T_MID,  beat_data(2));
        @(negedge clk);
        bus.pkt_in_valid = 1'b1;
        bus.pkt_in       = {T_MID, 4'd0, beat_data(3)};
        reset            = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready",  bus.pkt_in_ready, 1);
        check("mid_rst_out_valid", bus.metadata_out_valid, 0);
        check("mid_rst_out_data",  bus.metadata_out, 0);
        check("mid_rst_meta_cnt",  meta_cnt, 0);
        check("mid_rst_drop_cnt",  drop_cnt, 0);
        @(negedge clk);
        reset            = 1'b0;
        bus.pkt_in_valid = 1'b0;
        send_beat(T_MID,  beat_data(4));
        send_beat(T_TAIL, beat_data(5));
        @(negedge clk);
        check("post_rst_no_valid", bus.metadata_out_valid, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);
        send_pkt(16'h0800, 8'h45, 8'h06, 16'd52, 4'd8, 8'h10, 16'h4000, 32'hD0D0D0D0, 32'hD1D1D1D1, 16'h7000, 6);
        @(negedge clk);
        check("clean_word", bus.metadata_out, EXP_D);
        @(negedge clk);
        check("clean_meta_cnt", meta_cnt, 1);
        check("clean_drop_cnt", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
